// File: rtl/sprite_rom_fetch_if.sv
// sprite_rom_fetch_if: 16-bit burst SDRAM controller channel.
// master = fetch adapter side, slave = controller side.
interface sprite_rom_fetch_if;
   logic [24:0] ram_addr;
   logic        ram_req;
   logic        ram_refresh;
   logic        ram_ack;
   logic        ram_valid;
   logic [15:0] ram_data;

   modport master (
      output ram_addr, ram_req, ram_refresh,
      input  ram_ack, ram_valid, ram_data
   );

   modport slave (
      input  ram_addr, ram_req, ram_refresh,
      output ram_ack, ram_valid, ram_data
   );
endinterface

// File: rtl/sprite_rom_fetch.sv
// sprite_rom_fetch: renderer sprite-ROM port to 4-beat SDRAM bursts.
// Optional hit cache: define SPRITE_FETCH_CACHE_EN.
module sprite_rom_fetch #(
   parameter int BURST_LEN = 4
) (
   input  logic                      clk_ram,
   input  logic                      reset,
   input  logic                      req,
   input  logic [24:0]               addr,
   input  logic                      refresh,
   input  logic                      flush,
   output logic [63:0]               data,
   output logic                      rdy,
   output logic                      overrun,
   sprite_rom_fetch_if.master        ram
);

   generate
      if (BURST_LEN != 4) begin : g_bad_len
         $error("sprite_rom_fetch: BURST_LEN must be 4");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE, ISSUE, BURST, DONE, REFRESH
   } state_t;

   state_t      state, state_n;
   logic        req_q, refresh_q;
   logic        req_edge, refresh_edge;
   logic        slot_v;
   logic [21:0] slot_tag;
   logic        ref_pend;
   logic        hit_pend;
   logic        hit;
   logic [1:0]  beat;
   logic [47:0] asm_q;
   logic [21:0] addr_q;
   logic        take_fetch, take_hit;
   logic        fetch_ack, beat_en, beat_last;
   logic        ref_done;

   assign req_edge     = req & ~req_q;
   assign refresh_edge = refresh & ~refresh_q;

   always_ff @(posedge clk_ram) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n         = state;
      take_fetch      = 1'b0;
      take_hit        = 1'b0;
      fetch_ack       = 1'b0;
      beat_en         = 1'b0;
      beat_last       = 1'b0;
      ref_done        = 1'b0;
      ram.ram_req     = 1'b0;
      ram.ram_refresh = 1'b0;
      ram.ram_addr    = {addr_q, 3'b000};
      unique case (state)
         IDLE: begin
            if (slot_v) begin
               take_fetch = 1'b1;
               state_n    = ISSUE;
            end else if (hit_pend) begin
               take_hit = 1'b1;
               state_n  = DONE;
            end else if (ref_pend) begin
               state_n = REFRESH;
            end
         end
         ISSUE: begin
            ram.ram_req = 1'b1;
            if (ram.ram_ack) begin
               fetch_ack = 1'b1;
               state_n   = BURST;
            end
         end
         BURST: begin
            if (ram.ram_valid) begin
               beat_en = 1'b1;
               if (beat == 2'd3) begin
                  beat_last = 1'b1;
                  state_n   = DONE;
               end
            end
         end
         DONE: state_n = IDLE;
         REFRESH: begin
            ram.ram_refresh = 1'b1;
            if (ram.ram_ack) begin
               ref_done = 1'b1;
               state_n  = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // A consumed slot being refilled in the same cycle loses nothing.
   always_ff @(posedge clk_ram) begin
      if (reset) begin
         req_q     <= 1'b0;
         refresh_q <= 1'b0;
         slot_v    <= 1'b0;
         slot_tag  <= '0;
         ref_pend  <= 1'b0;
         hit_pend  <= 1'b0;
         overrun   <= 1'b0;
         addr_q    <= '0;
      end else begin
         req_q     <= req;
         refresh_q <= refresh;
         if (take_fetch) begin
            slot_v <= 1'b0;
            addr_q <= slot_tag;
         end
         if (req_edge && !hit) begin
            slot_v   <= 1'b1;
            slot_tag <= addr[24:3];
            if (slot_v && !take_fetch) overrun <= 1'b1;
         end
         if (take_hit) hit_pend <= 1'b0;
         if (hit)      hit_pend <= 1'b1;
         if (ref_done)          ref_pend <= 1'b0;
         else if (refresh_edge) ref_pend <= 1'b1;
      end
   end

   always_ff @(posedge clk_ram) begin
      if (reset) begin
         beat  <= 2'd0;
         asm_q <= '0;
         data  <= '0;
         rdy   <= 1'b0;
      end else begin
         rdy <= beat_last | take_hit;
         if (fetch_ack) beat <= 2'd0;
         if (beat_en) begin
            beat <= beat + 2'd1;
            unique case (beat)
               2'd0:    asm_q[15:0]  <= ram.ram_data;
               2'd1:    asm_q[31:16] <= ram.ram_data;
               2'd2:    asm_q[47:32] <= ram.ram_data;
               default: ;
            endcase
         end
         if (beat_last) data <= {ram.ram_data, asm_q};
      end
   end

`ifdef SPRITE_FETCH_CACHE_EN
   // data already holds the last completed line, so only the tag is kept.
   logic        cache_v;
   logic [21:0] cache_tag;
   logic        unused_lsb;

   assign unused_lsb = ^addr[2:0];
   assign hit = req_edge && cache_v && (state == IDLE)
              && !slot_v && (addr[24:3] == cache_tag);

   always_ff @(posedge clk_ram) begin
      if (reset) begin
         cache_v   <= 1'b0;
         cache_tag <= '0;
      end else if (flush) begin
         cache_v <= 1'b0;
      end else if (beat_last) begin
         cache_v   <= 1'b1;
         cache_tag <= addr_q;
      end
   end
`else
   logic unused_lsb;

   assign unused_lsb = ^{addr[2:0], flush};
   assign hit        = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_rom_fetch.sv
// tb_sprite_rom_fetch: directed plus randomized checks of sprite_rom_fetch
// against a behavioural SDRAM/line model.
module tb_sprite_rom_fetch;
   logic        clk_ram = 1'b0;
   logic        reset   = 1'b1;
   logic        req     = 1'b0;
   logic [24:0] addr    = '0;
   logic        refresh = 1'b0;
   logic        flush   = 1'b0;
   logic [63:0] data;
   logic        rdy;
   logic        overrun;

   sprite_rom_fetch_if ram();

   sprite_rom_fetch dut (
      .clk_ram (clk_ram),
      .reset   (reset),
      .req     (req),
      .addr    (addr),
      .refresh (refresh),
      .flush   (flush),
      .data    (data),
      .rdy     (rdy),
      .overrun (overrun),
      .ram     (ram)
   );

   always #5 clk_ram = ~clk_ram;

   int passed = 0;
   int total  = 0;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Memory contents: the test-plan line at 0x0123458, a hash elsewhere.
   function automatic logic [15:0] bv(input logic [24:0] a, input int b);
      if (a == 25'h0123458) return 16'(32'h1111 * (b + 1));
      return a[18:3] ^ 16'(32'h9e37 * (b + 1));
   endfunction

   function automatic logic [63:0] line(input logic [24:0] a);
      logic [24:0] m;
      m = {a[24:3], 3'b000};
      return {bv(m, 3), bv(m, 2), bv(m, 1), bv(m, 0)};
   endfunction

   // Controller model: ack after ack_dly, then 4 beats with random gaps.
   int          cs = 0, cnt = 0, cb = 0;
   int          ack_dly = 2, hold_at = 4, stray_n = 0;
   int          cyc = 0, last_beat_cyc = 0, overlap = 0;
   logic [24:0] caddr;
   bit          cref;
   logic [25:0] log_q[$];

   always @(posedge clk_ram) begin
      cyc++;
      ram.ram_ack   <= 1'b0;
      ram.ram_valid <= 1'b0;
      if (ram.ram_req && ram.ram_refresh) overlap++;
      if (reset) begin
         cs = 0;
      end else begin
         case (cs)
            0: begin
               if (stray_n > 0) begin
                  ram.ram_valid <= 1'b1;
                  ram.ram_data  <= 16'hdead;
                  stray_n--;
               end else if (ram.ram_req || ram.ram_refresh) begin
                  cref  = ram.ram_refresh;
                  caddr = ram.ram_addr;
                  cnt   = ack_dly;
                  cs    = 1;
               end
            end
            1: begin
               if (cnt > 0) cnt--;
               else begin
                  ram.ram_ack <= 1'b1;
                  log_q.push_back({cref, caddr});
                  cb = 0;
                  cs = cref ? 3 : 2;
               end
            end
            2: begin
               if (cb < hold_at && $urandom_range(0, 2) != 0) begin
                  ram.ram_valid <= 1'b1;
                  ram.ram_data  <= bv(caddr, cb);
                  if (cb == 3) last_beat_cyc = cyc;
                  cb++;
                  if (cb == 4) cs = 3;
               end
            end
            default: cs = 0;
         endcase
      end
   end

   int          rdy_cnt = 0, rdy_cyc = 0, req_rise = 0;
   logic [63:0] rdy_data = '0;
   logic        req_prev = 1'b0;

   always @(negedge clk_ram) begin
      if (rdy === 1'b1) begin
         rdy_cnt++;
         rdy_cyc  = cyc;
         rdy_data = data;
      end
      if (ram.ram_req === 1'b1 && !req_prev) req_rise++;
      req_prev = (ram.ram_req === 1'b1);
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk_ram);
      #1;
   endtask

   task automatic wait_rdy(input int n, input string tag);
      int t;
      t = 0;
      while (rdy_cnt < n && t < 300) begin
         step(1);
         t++;
      end
      check(tag, 64'(rdy_cnt >= n), 64'd1);
   endtask

   task automatic fetch(input logic [24:0] a, input int hold);
      req  = 1'b1;
      addr = a;
      step(hold);
      req  = 1'b0;
   endtask

   initial begin : timeout
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          n0, r0, l0, t, nref, seen_ref;
      logic [24:0] a;
      logic [24:0] exp_addr[$];
      bit          do_ref;
      int          lag;

      // Reset state
      step(3);
      check("rst_data", data, 64'd0);
      check("rst_rdy", 64'(rdy), 64'd0);
      check("rst_ovr", 64'(overrun), 64'd0);
      check("rst_req", 64'(ram.ram_req), 64'd0);
      check("rst_ref", 64'(ram.ram_refresh), 64'd0);
      check("rst_addr", 64'(ram.ram_addr), 64'd0);
      reset = 1'b0;
      step(2);

      // Single fetch with E+2 issue timing
      ack_dly = 2;
      n0 = rdy_cnt;
      r0 = req_rise;
      req  = 1'b1;
      addr = 25'h0123458;
      step(1);
      req = 1'b0;
      check("e1_req", 64'(ram.ram_req), 64'd0);
      step(1);
      check("e2_req", 64'(ram.ram_req), 64'd1);
      check("e2_addr", 64'(ram.ram_addr), 64'h0123458);
      wait_rdy(n0 + 1, "single_to");
      check("single_lat", 64'(rdy_cyc - last_beat_cyc), 64'd1);
      check("single_data", rdy_data, 64'h4444_3333_2222_1111);
      step(1);
      check("single_hold", data, 64'h4444_3333_2222_1111);
      step(10);
      check("single_rdys", 64'(rdy_cnt - n0), 64'd1);
      check("single_reqs", 64'(req_rise - r0), 64'd1);

      // Long req counts once
      n0 = rdy_cnt;
      r0 = req_rise;
      fetch(25'h0001230, 4);
      wait_rdy(n0 + 1, "long_to");
      check("long_data", rdy_data, line(25'h0001230));
      step(12);
      check("long_rdys", 64'(rdy_cnt - n0), 64'd1);
      check("long_reqs", 64'(req_rise - r0), 64'd1);

      // Simultaneous req and refresh edges: fetch first
      n0 = rdy_cnt;
      l0 = log_q.size();
      req     = 1'b1;
      refresh = 1'b1;
      addr    = 25'h0456780;
      step(1);
      req     = 1'b0;
      refresh = 1'b0;
      wait_rdy(n0 + 1, "arb_to");
      step(12);
      check("arb_n", 64'(log_q.size() - l0), 64'd2);
      if (log_q.size() >= l0 + 2) begin
         check("arb_first", 64'(log_q[l0]), {38'd0, 1'b0, 25'h0456780});
         check("arb_second", 64'(log_q[l0 + 1][25]), 64'd1);
      end
      check("arb_overlap", 64'(overlap), 64'd0);

      // Overrun: two req edges while a burst is stalled
      n0 = rdy_cnt;
      l0 = log_q.size();
      hold_at = 0;
      fetch(25'h0000300, 1);
      t = 0;
      while (log_q.size() == l0 && t < 100) begin
         step(1);
         t++;
      end
      check("ovr_ack_to", 64'(log_q.size() > l0), 64'd1);
      step(1);
      fetch(25'h0000100, 1);
      step(1);
      fetch(25'h0000200, 1);
      step(1);
      check("ovr_flag", 64'(overrun), 64'd1);
      hold_at = 4;
      wait_rdy(n0 + 2, "ovr_to");
      check("ovr_data", rdy_data, line(25'h0000200));
      step(12);
      check("ovr_n", 64'(log_q.size() - l0), 64'd2);
      if (log_q.size() >= l0 + 2)
         check("ovr_addr", 64'(log_q[l0 + 1]), {39'd0, 25'h0000200});
      check("ovr_sticky", 64'(overrun), 64'd1);

      // Reset mid-burst, then stray beats
      hold_at = 2;
      n0 = rdy_cnt;
      fetch(25'h0000ab0, 1);
      t = 0;
      while (cb < 2 && t < 100) begin
         step(1);
         t++;
      end
      check("mid_beats_to", 64'(cb >= 2), 64'd1);
      step(2);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      check("mid_data", data, 64'd0);
      check("mid_rdy", 64'(rdy), 64'd0);
      check("mid_ovr", 64'(overrun), 64'd0);
      check("mid_req", 64'(ram.ram_req), 64'd0);
      check("mid_addr", 64'(ram.ram_addr), 64'd0);
      hold_at = 4;
      stray_n = 2;
      step(8);
      check("stray_rdy", 64'(rdy_cnt - n0), 64'd0);
      check("stray_data", data, 64'd0);
      fetch(25'h1f00f08, 1);
      wait_rdy(n0 + 1, "post_to");
      check("post_data", rdy_data, line(25'h1f00f08));
      step(12);

`ifdef SPRITE_FETCH_CACHE_EN
      // Cache hit and flush
      n0 = rdy_cnt;
      r0 = req_rise;
      fetch(25'h0777770, 1);
      wait_rdy(n0 + 1, "c_fill_to");
      step(4);
      req  = 1'b1;
      addr = 25'h0777770;
      step(1);
      req = 1'b0;
      check("hit_e1", 64'(rdy), 64'd0);
      step(1);
      check("hit_e2", 64'(rdy), 64'd1);
      check("hit_data", data, line(25'h0777770));
      step(10);
      check("hit_noreq", 64'(req_rise - r0), 64'd1);
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      n0 = rdy_cnt;
      fetch(25'h0777770, 1);
      wait_rdy(n0 + 1, "flush_to");
      step(4);
      check("flush_req", 64'(req_rise - r0), 64'd2);
`endif

      // Randomized fetches with interleaved refreshes
      l0   = log_q.size();
      nref = 0;
      for (int i = 0; i < 20; i++) begin
         a       = 25'($urandom);
         do_ref  = ($urandom_range(0, 2) == 0);
         lag     = $urandom_range(0, 3);
         ack_dly = $urandom_range(0, 4);
         exp_addr.push_back({a[24:3], 3'b000});
         if (do_ref) nref++;
         n0 = rdy_cnt;
         req  = 1'b1;
         addr = a;
         if (do_ref && lag == 0) refresh = 1'b1;
         step(1);
         req     = 1'b0;
         refresh = 1'b0;
         if (do_ref && lag > 0) begin
            step(lag);
            refresh = 1'b1;
            step(1);
            refresh = 1'b0;
         end
         wait_rdy(n0 + 1, "rnd_to");
         check("rnd_data", rdy_data, line(a));
         step(12);
      end
      seen_ref = 0;
      for (int i = l0; i < log_q.size(); i++) begin
         if (log_q[i][25]) seen_ref++;
         else if (exp_addr.size() > 0)
            check("rnd_addr", 64'(log_q[i][24:0]),
                  64'(exp_addr.pop_front()));
      end
      check("rnd_left", 64'(exp_addr.size()), 64'd0);
      check("rnd_refs", 64'(seen_ref), 64'(nref));
      check("rnd_overlap", 64'(overlap), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/sprite_rom_fetch.md
# sprite_rom_fetch

Memory-side adapter between the GA22 sprite renderer's sprite-ROM port (`sdr_req`/`sdr_addr`/`sdr_data`/`sdr_rdy`/`sdr_refresh`) and a 16-bit burst SDRAM controller channel. It runs in the `clk_ram` domain. It turns each renderer request into one 4-beat burst, assembles the 64-bit bitplane word and returns it with a ready pulse. It also forwards renderer refresh windows to the controller and arbitrates them against fetches.

## Interface
Parameters:
- `BURST_LEN`, 4: 16-bit beats per fetch. Fixed at 4; any other value is a synthesis error.

Ports:
- `clk_ram`  in  1  memory clock; integer multiple of the renderer clock, phase-related.
- `reset`  in  1  synchronous, active-high; clock `clk_ram`.
- `req`  in  1  renderer request. A 0→1 edge starts one fetch.
- `addr`  in  25  renderer byte address, 8-byte aligned. Sampled on the `req` edge.
- `refresh`  in  1  renderer refresh window. A 0→1 edge requests one refresh.
- `flush`  in  1  invalidates the hit cache; only meaningful with the cache compiled in.
- `data`  out  64  assembled bitplanes. Beat 0 → `[15:0]` … beat 3 → `[63:48]`. Held until the next completion.
- `rdy`  out  1  one-cycle pulse; `data` is valid in the same cycle.
- `overrun`  out  1  sticky; a pending request was overwritten. Cleared only by reset.
- `ram_addr`  out  25  controller byte address; `[2:0]` is always 0.
- `ram_req`  out  1  fetch request, held until `ram_ack`.
- `ram_refresh`  out  1  refresh request, held until `ram_ack`.
- `ram_ack`  in  1  controller accepted the current request.
- `ram_valid`  in  1  read beat strobe.
- `ram_data`  in  16  read beat.

## Operation
- Edge detection: `req_q` and `refresh_q` are registered each cycle. A multi-cycle-high `req` from the slower clock counts once.
- Pending slots: one fetch slot (address plus valid) and one refresh flag.
  - A new `req` edge while the fetch slot is valid overwrites the address and sets `overrun`.
  - A `refresh` edge while the flag is already set is absorbed.
- States:
  - IDLE: if the fetch slot is valid, go to ISSUE. Otherwise, if the refresh flag is set, go to REFRESH. A fetch has priority when both are pending.
  - ISSUE: drive `ram_req=1` and `ram_addr={slot_addr[24:3],3'b000}`, and clear the fetch slot. On `ram_ack`, drop `ram_req`, clear the beat counter and go to BURST.
  - BURST: on each `ram_valid`, shift `ram_data` into the assembly register at lane `beat`, then increment the 2-bit `beat`. On the beat-3 strobe, go to DONE.
  - DONE: copy the assembly register to `data`, pulse `rdy`, go to IDLE.
  - REFRESH: drive `ram_refresh=1` until `ram_ack`, clear the refresh flag, go to IDLE.
- `ram_valid` outside BURST is ignored. This covers stale beats arriving after a reset.
- `ram_req` and `ram_refresh` are never high together.
- Reset, including mid-burst: state=IDLE; slots, flag and `beat` cleared; `data=0`, `rdy=0`, `overrun=0`, `ram_req=0`, `ram_refresh=0`, `ram_addr=0`; cache invalid.

## Timing
- Edge detected in cycle E (`req_q` was 0 and `req` is 1 in E). The slot is written in E, and IDLE→ISSUE is taken in E+1.
- `ram_req` first asserts in cycle E+2 when the block is idle.
- Latency: `rdy` rises 1 cycle after the cycle carrying the beat-3 `ram_valid`.
- Simultaneous `req` edge and DONE: the edge fills the slot, and the next ISSUE follows immediately after IDLE.
- Simultaneous `req` and `refresh` edges: the fetch is served first, then the refresh.

## Configuration
- `SPRITE_FETCH_CACHE_EN` defined: the last completed address and its `data` are kept with a valid bit.
  - A `req` edge whose `addr` matches while the cache is valid and IDLE is a hit. It produces a `rdy` pulse at E+2 with `data` unchanged and no `ram_req`.
  - The cache is invalidated by `flush` or reset.
- Not defined: every request goes to SDRAM, and `flush` is ignored.

## Test plan
- Single fetch: `req` edge with `addr=0x0123458`, controller acks after 3 cycles, beats 0x1111, 0x2222, 0x3333, 0x4444 → `ram_addr=0x0123458`, `data=0x4444_3333_2222_1111`, exactly one `rdy` pulse.
- Long `req`: hold `req` high for 4 cycles → exactly one `ram_req` transaction and one `rdy`.
- Arbitration: `req` and `refresh` edges in the same cycle → the fetch completes first, then `ram_refresh` asserts. The two requests never overlap.
- Overrun: two `req` edges, 0x100 then 0x200, during a burst → one later fetch, to 0x200 only, and `overrun=1`.
- Reset mid-burst after 2 beats, then 2 stray `ram_valid` beats → no `rdy`, all outputs 0, and a following fetch returns correct data.
- With `SPRITE_FETCH_CACHE_EN`: repeat the same address → second `rdy` at E+2 with no `ram_req`. After a `flush` pulse, the same address issues `ram_req` again.
